// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression control FSM: message word load, working-variable init,
// 64 rounds and hash update. Drives only enables/selects of the datapath.
module sha256_round_ctrl #(
  parameter int unsigned WORDS  = 16,
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             first_blk,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             wt_load,
  output logic [IDX_W-1:0] word_idx,
  output logic             h_init,
  output logic             sel_A,
  output logic             rnd_en,
  output logic [IDX_W-1:0] rnd_idx,
  output logic             sel_W,
  output logic             h_update,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_RND  = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W:0]   WORDS_X   = (IDX_W + 1)'(WORDS);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] word_cnt, word_cnt_nxt;
  logic [IDX_W-1:0] rnd_cnt, rnd_cnt_nxt;
  logic             fb_q, fb_nxt;
  logic             first_q, first_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      rnd_cnt  <= '0;
      fb_q     <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      rnd_cnt  <= rnd_cnt_nxt;
      fb_q     <= fb_nxt;
      first_q  <= first_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    rnd_cnt_nxt  = rnd_cnt;
    fb_nxt       = fb_q;
    first_nxt    = first_q;
    word_ready   = 1'b0;
    h_init       = 1'b0;
    sel_A        = 1'b0;
    rnd_en       = 1'b0;
    sel_W        = 1'b0;
    h_update     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          fb_nxt       = first_blk;
          first_nxt    = 1'b1;
          word_cnt_nxt = '0;
          state_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        // first_q marks the first LOAD cycle even if no word arrives in it
        h_init     = first_q & fb_q;
        first_nxt  = 1'b0;
        if (word_valid) begin
          if (word_cnt == LAST_WORD) begin
            word_cnt_nxt = '0;
            state_nxt    = S_INIT;
          end else begin
            word_cnt_nxt = word_cnt + 1'b1;
          end
        end
      end
      S_INIT: begin
        busy        = 1'b1;
        sel_A       = 1'b1;
        rnd_cnt_nxt = '0;
        state_nxt   = S_ROUND;
      end
      S_ROUND: begin
        busy   = 1'b1;
        rnd_en = 1'b1;
        sel_W  = ({1'b0, rnd_cnt} >= WORDS_X);
        if (rnd_cnt == LAST_RND) begin
          rnd_cnt_nxt = '0;
          state_nxt   = S_UPDATE;
        end else begin
          rnd_cnt_nxt = rnd_cnt + 1'b1;
        end
      end
      S_UPDATE: begin
        busy      = 1'b1;
        h_update  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt    = S_IDLE;
        word_cnt_nxt = '0;
        rnd_cnt_nxt  = '0;
        first_nxt    = 1'b0;
      end
    endcase
  end

  assign wt_load  = word_valid & word_ready;
  assign word_idx = word_cnt;
  assign rnd_idx  = rnd_cnt;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: stimulus queues expected word/round
// indices and done cycles; a negedge monitor pops and compares.
module tb_sha256_round_ctrl;
  localparam int WORDS  = 16;
  localparam int ROUNDS = 64;
  localparam int IDX_W  = 6;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             start = 1'b0;
  logic             first_blk = 1'b0;
  logic             word_valid = 1'b0;
  logic             word_ready, wt_load, h_init, sel_A, rnd_en, sel_W;
  logic             h_update, busy, done;
  logic [IDX_W-1:0] word_idx, rnd_idx;

  sha256_round_ctrl #(.WORDS(WORDS), .ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .first_blk(first_blk),
    .word_valid(word_valid), .word_ready(word_ready), .wt_load(wt_load),
    .word_idx(word_idx), .h_init(h_init), .sel_A(sel_A), .rnd_en(rnd_en),
    .rnd_idx(rnd_idx), .sel_W(sel_W), .h_update(h_update), .busy(busy),
    .done(done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int exp_word[$];
  int exp_rnd[$];
  int exp_done[$];
  int h_init_cnt = 0, h_init_cyc = 0;
  int sel_a_cnt = 0, sel_a_cyc = 0;
  int h_upd_cnt = 0, h_upd_cyc = 0;
  int done_cnt = 0, done_cyc = 0;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: per-cycle invariants plus scoreboard pops on each DUT event
  always @(negedge CLK) begin
    int sum;
    int e;
    if (!RST) begin
      sum = int'(h_init) + int'(sel_A) + int'(rnd_en) + int'(h_update) + int'(done);
      check("strobe_onehot", int'(sum > 1), 0);
      check("wt_load_eq", int'(wt_load), int'(word_valid & word_ready));
      if (sum != 0 || word_ready) check("busy_active", int'(busy), 1);
      if (wt_load) begin
        if (exp_word.size() == 0) check("unexpected_wt_load", 1, 0);
        else begin
          e = exp_word.pop_front();
          check("word_idx", int'(word_idx), e);
        end
      end
      if (rnd_en) begin
        if (exp_rnd.size() == 0) check("unexpected_rnd_en", 1, 0);
        else begin
          e = exp_rnd.pop_front();
          check("rnd_idx", int'(rnd_idx), e);
          check("sel_W", int'(sel_W), int'(e >= WORDS));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_done.pop_front();
          check("done_cycle", cyc, e);
        end
      end
      if (h_init) begin h_init_cnt++; h_init_cyc = cyc; end
      if (sel_A) begin sel_a_cnt++; sel_a_cyc = cyc; end
      if (h_update) begin h_upd_cnt++; h_upd_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({word_ready, wt_load, h_init, sel_A, rnd_en, sel_W,
                      h_update, busy, done, word_idx, rnd_idx}), 0);
  endtask

  // One block from IDLE; valid is high on every period-th LOAD cycle.
  // poke pulses start once mid-ROUND and once in DONE.
  task automatic run_block(input logic fb, input int period, input bit poke);
    int s, k, acc, i, d0;
    s = cyc; k = 0; acc = 0; i = 0; d0 = done_cnt;
    h_init_cnt = 0; sel_a_cnt = 0; h_upd_cnt = 0;
    for (int w = 0; w < WORDS; w++) exp_word.push_back(w);
    for (int r = 0; r < ROUNDS; r++) exp_rnd.push_back(r);
    first_blk = fb;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_blk = 1'b0;
    while (acc < WORDS && i < 200) begin
      word_valid = ((i % period) == 0);
      if (word_valid) begin acc++; k = cyc; end
      tick();
      i++;
    end
    word_valid = 1'b0;
    check("words_driven", acc, WORDS);
    exp_done.push_back(k + 67);
    if (poke) begin
      while (cyc < k + 30) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      while (cyc < k + 67) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int t = 0; t < 300 && done_cnt == d0; t++) tick();
    check("done_seen", done_cnt - d0, 1);
    if (period == 1) check("start_to_done", done_cyc - s, 83);
    check("h_init_count", h_init_cnt, fb ? 1 : 0);
    if (fb) check("h_init_cycle", h_init_cyc, s + 1);
    check("sel_A_count", sel_a_cnt, 1);
    check("sel_A_cycle", sel_a_cyc, k + 1);
    check("h_update_count", h_upd_cnt, 1);
    check("h_update_cycle", h_upd_cyc, k + 66);
    tick();
    tick();
    check("idle_busy", int'(busy), 0);
    check("idle_word_ready", int'(word_ready), 0);
    check("words_left", exp_word.size(), 0);
    check("rounds_left", exp_rnd.size(), 0);
    check("done_left", exp_done.size(), 0);
  endtask

  initial begin
    bit found;
    #3 RST = 1'b1;
    #1 check_all_zero("reset_outputs");
    tick();
    tick();
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_busy0", int'(busy), 0);
      check("idle_ready0", int'(word_ready), 0);
    end

    run_block(1'b1, 1, 1'b0);
    run_block(1'b1, 3, 1'b0);
    run_block(1'b0, 1, 1'b1);
    run_block(1'b0, 2, 1'b0);

    // Partial block, reset asserted mid-cycle while round 30 is active
    for (int w = 0; w < WORDS; w++) exp_word.push_back(w);
    for (int r = 0; r < 30; r++) exp_rnd.push_back(r);
    first_blk = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    word_valid = 1'b1;
    for (int w = 0; w < WORDS; w++) tick();
    word_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      if (rnd_en && int'(rnd_idx) == 30) found = 1'b1;
      else tick();
    end
    check("reached_round30", int'(found), 1);
    #2 RST = 1'b1;
    #1 check_all_zero("async_reset_outputs");
    check("rounds_before_reset", exp_rnd.size(), 0);
    exp_word.delete();
    exp_rnd.delete();
    exp_done.delete();
    tick();
    tick();
    RST = 1'b0;
    tick();
    run_block(1'b1, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
